// File: rtl/wb_ddr2_pkg.sv
// wb_ddr2_pkg: shared FSM state type, Wishbone CTI/BTE codes
// and the posted-write entry layout for the DDR2 write buffer.
package wb_ddr2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_READ  = 2'd2
  } wb_st_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // 68-bit posted write: {adr, dat, sel}
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_entry_t;

endpackage

// File: rtl/wb_ddr2_wrbuf_fifo.sv
// wb_ddr2_wrbuf_fifo: 2**DEPTH_LOG2 entry posted-write FIFO.
// Ports: push/push_data, pop/head, registered full/empty, count.
module wb_ddr2_wrbuf_fifo
  import wb_ddr2_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                wb_clk,
  input  logic                wb_rst,
  input  logic                push,
  input  wr_entry_t           push_data,
  input  logic                pop,
  output wr_entry_t           head,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  wr_entry_t           mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic [DEPTH_LOG2:0] wr_nxt;
  logic [DEPTH_LOG2:0] rd_nxt;
  logic                do_push;
  logic                do_pop;

  // full is a register, so a push is refused while full
  // even when a pop happens in the same cycle
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign wr_nxt = wr_ptr + {{DEPTH_LOG2{1'b0}}, do_push};
  assign rd_nxt = rd_ptr + {{DEPTH_LOG2{1'b0}}, do_pop};

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      // extra pointer MSB tells a wrapped writer from an equal one
      full   <= (wr_nxt[DEPTH_LOG2] != rd_nxt[DEPTH_LOG2]) &&
                (wr_nxt[DEPTH_LOG2-1:0] == rd_nxt[DEPTH_LOG2-1:0]);
      empty  <= (wr_nxt == rd_nxt);
    end
  end

  always_ff @(posedge wb_clk) begin
    if (do_push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
    end
  end

  assign head  = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/wb_ddr2_wrbuf.sv
// wb_ddr2_wrbuf: posts CPU writes into a FIFO, drains them as classic
// singles to a DDR2 arbiter port; reads pass through once drained.
// Ports: wbs_* slave side, wbm_* master side, wr_err_o sticky error.
module wb_ddr2_wrbuf
  import wb_ddr2_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [2:0]  wbs_cti_i,
  input  logic [1:0]  wbs_bte_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  output logic        wr_err_o
);

  localparam logic [DEPTH_LOG2:0] ONE = (DEPTH_LOG2+1)'(1);

  wb_st_e              state;
  logic                ack_q;
  logic                err_q;
  wr_entry_t           head;
  wr_entry_t           push_data;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic                in_drain;
  logic                in_read;
  logic                wr_req;
  logic                rd_req;
  logic                wr_acc;
  logic                pop;
  logic                last_pop;
  logic                rd_done;

  assign in_drain = (state == ST_DRAIN);
  assign in_read  = (state == ST_READ);

  assign wr_req = wbs_cyc_i & wbs_stb_i & wbs_we_i;
  assign rd_req = wbs_cyc_i & wbs_stb_i & ~wbs_we_i;

  // ack_q blocks a second push of the beat being acked
  assign wr_acc = wr_req & ~full & ~ack_q & ~in_read;

  // err also retires the entry; rty leaves it at the head
  assign pop = in_drain & (wbm_ack_i | wbm_err_i);

  // a push in the same cycle keeps the drain going
  assign last_pop = pop & (count == ONE) & ~wr_acc;

  assign rd_done = (wbm_ack_i & (wbs_cti_i != CTI_INCR)) | ~wbs_cyc_i;

  assign push_data.adr = wbs_adr_i;
  assign push_data.dat = wbs_dat_i;
  assign push_data.sel = wbs_sel_i;

  wb_ddr2_wrbuf_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .wb_clk    (wb_clk),
    .wb_rst    (wb_rst),
    .push      (wr_acc),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state <= ST_IDLE;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= wr_acc;
      if (in_drain && wbm_err_i) begin
        err_q <= 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          // posted writes go first: read-after-write ordering
          if (!empty) begin
            state <= ST_DRAIN;
          end else if (rd_req) begin
            state <= ST_READ;
          end
        end
        ST_DRAIN: begin
          if (last_pop) begin
            state <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (rd_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign wr_err_o = err_q;

  // bus outputs decode the state register, so reset
  // drops wbm_cyc_o without waiting for a clock
  always_comb begin
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    wbm_sel_o = '0;
    wbm_cti_o = CTI_CLASSIC;
    wbm_bte_o = BTE_LINEAR;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbs_ack_o = ack_q;
    wbs_err_o = 1'b0;
    wbs_rty_o = 1'b0;
    wbs_dat_o = '0;
    unique case (1'b1)
      in_drain: begin
        wbm_adr_o = head.adr;
        wbm_dat_o = head.dat;
        wbm_sel_o = head.sel;
        wbm_cti_o = CTI_EOB;
        wbm_bte_o = BTE_LINEAR;
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
      end
      in_read: begin
        wbm_adr_o = wbs_adr_i;
        wbm_dat_o = wbs_dat_i;
        wbm_sel_o = wbs_sel_i;
        wbm_cti_o = wbs_cti_i;
        wbm_bte_o = wbs_bte_i;
        wbm_cyc_o = wbs_cyc_i;
        wbm_stb_o = wbs_stb_i;
        wbm_we_o  = 1'b0;
        wbs_ack_o = wbm_ack_i;
        wbs_err_o = wbm_err_i;
        wbs_rty_o = wbm_rty_i;
        wbs_dat_o = wbm_dat_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_ddr2_wrbuf.sv
// tb_wb_ddr2_wrbuf: directed and random checks of the write buffer
// against a queue/memory reference model and a simple DDR2 port model.
module tb_wb_ddr2_wrbuf;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic [2:0]  wbs_cti_i;
  logic [1:0]  wbs_bte_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic        wbs_rty_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        wbm_rty_i;
  logic        wr_err_o;

  always #5 wb_clk = ~wb_clk;

  wb_ddr2_wrbuf #(.DEPTH_LOG2(2)) dut (
    .wb_clk    (wb_clk),
    .wb_rst    (wb_rst),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_cti_i (wbs_cti_i),
    .wbs_bte_i (wbs_bte_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_dat_o (wbs_dat_o),
    .wbs_ack_o (wbs_ack_o),
    .wbs_err_o (wbs_err_o),
    .wbs_rty_o (wbs_rty_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_cti_o (wbm_cti_o),
    .wbm_bte_o (wbm_bte_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .wbm_err_i (wbm_err_i),
    .wbm_rty_i (wbm_rty_i),
    .wr_err_o  (wr_err_o)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  bit          ack_seen = 0;
  logic [31:0] rd_seen = '0;
  bit          slv_hold = 0;
  int          slv_lat = 0;
  int          wcnt = 0;
  int          rty_left = 0;
  bit          err_next = 0;
  bit          rnd_lat = 0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0]  s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: port model answers at negedge, outputs sampled after
  task automatic tick();
    logic [31:0] o;
    ent_t        e;
    @(negedge wb_clk);
    if (wbm_cyc_o && wbm_stb_o && !slv_hold) begin
      if (wcnt >= slv_lat) begin
        wcnt = 0;
        if (rnd_lat) slv_lat = int'($urandom_range(0, 3));
        if (wbm_we_o && rty_left > 0) begin
          wbm_rty_i = 1'b1;
          rty_left--;
        end else if (wbm_we_o && err_next) begin
          wbm_err_i = 1'b1;
          err_next = 0;
        end else begin
          wbm_ack_i = 1'b1;
          if (!wbm_we_o)
            wbm_dat_i = slv_mem.exists(wbm_adr_o) ?
                        slv_mem[wbm_adr_o] : dflt(wbm_adr_o);
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
    #1;
    ack_seen = wbs_ack_o;
    rd_seen  = wbs_dat_o;
    if (wbm_cyc_o && wbm_stb_o && wbm_we_o && (wbm_ack_i || wbm_err_i)) begin
      chk("drain_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("drain_beat",
            {wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cti_o, wbm_bte_o},
            {1'b1, e.adr, e.dat, e.sel, 3'b111, 2'b00});
        if (wbm_ack_i) begin
          o = slv_mem.exists(e.adr) ? slv_mem[e.adr] : dflt(e.adr);
          slv_mem[e.adr] = merge(o, e.dat, e.sel);
        end
      end
      done_cnt++;
    end
    @(posedge wb_clk);
    #1;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_rty_i = 1'b0;
    wbm_dat_i = '0;
  endtask

  task automatic post(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    ent_t e;
    e.adr = a;
    e.dat = d;
    e.sel = s;
    exp_q.push_back(e);
    ref_mem[a] = merge(ref_rd(a), d, s);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int bound,
                          output int n);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b1;
    wbs_adr_i = a;
    wbs_dat_i = d;
    wbs_sel_i = s;
    wbs_cti_i = 3'b000;
    n = 0;
    ack_seen = 0;
    while (!ack_seen && n < bound) begin
      tick();
      n++;
    end
    wbs_stb_i = 1'b0;
    chk("wr_ack", ack_seen, 1'b1);
    if (ack_seen) post(a, d, s);
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [2:0] cti,
                         input int bound, output int n);
    logic [31:0] got;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b0;
    wbs_adr_i = a;
    wbs_dat_i = '0;
    wbs_sel_i = 4'hF;
    wbs_cti_i = cti;
    n = 0;
    ack_seen = 0;
    got = '0;
    while (!ack_seen && n < bound) begin
      tick();
      n++;
      got = rd_seen;
    end
    wbs_stb_i = 1'b0;
    chk("rd_ack", ack_seen, 1'b1);
    chk("rd_data", got, ref_rd(a));
  endtask

  task automatic idle();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_cti_i = 3'b000;
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || wbm_cyc_o) && k < bound) begin
      tick();
      k++;
    end
    chk("drain_done", {exp_q.size() == 0, wbm_cyc_o}, 2'b10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int d0;
    bit any;
    logic [31:0] a;
    wb_rst = 1'b1;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0;
    wbs_cti_i = '0; wbs_bte_i = '0;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wbm_dat_i = '0; wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0;
    repeat (3) @(posedge wb_clk);
    #1;
    chk("rst_ctl", {wbs_ack_o, wbs_err_o, wbs_rty_o, wbm_cyc_o,
                    wbm_stb_o, wbm_we_o, wr_err_o}, 7'd0);
    chk("rst_bus", {wbm_adr_o, wbm_dat_o, wbs_dat_o, wbm_sel_o,
                    wbm_cti_o, wbm_bte_o}, 0);
    wb_rst = 1'b0;
    tick();

    // single posted write, slow downstream ack
    slv_lat = 5;
    d0 = done_cnt;
    wb_write(32'h100, 32'hDEAD_BEEF, 4'hF, 20, n);
    chk("wr1_ack_lat", n, 2);
    idle();
    drain(50);
    chk("wr1_one_xfer", done_cnt - d0, 1);

    // five writes into a 4-deep buffer, downstream stalled
    slv_hold = 1;
    slv_lat = 0;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      wb_write(32'h180 + 32'(4 * i), $urandom, 4'hF, 10, n);
      chk("full_ack_lat", n, 2);
    end
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b1;
    wbs_adr_i = 32'h190;
    wbs_dat_i = 32'hCAFE_0005;
    wbs_sel_i = 4'hF;
    any = 0;
    repeat (6) begin
      tick();
      any |= ack_seen;
    end
    chk("full_stall", any, 1'b0);
    chk("full_no_pop", done_cnt - d0, 0);
    slv_hold = 0;
    n = 0;
    ack_seen = 0;
    while (!ack_seen && n < 10) begin
      tick();
      n++;
    end
    chk("full_5th_ack", ack_seen, 1'b1);
    chk("full_after_pop", done_cnt - d0 >= 1, 1'b1);
    if (ack_seen) post(32'h190, 32'hCAFE_0005, 4'hF);
    idle();
    drain(50);
    chk("full_total", done_cnt - d0, 5);

    // read-after-write ordering
    slv_lat = 3;
    d0 = done_cnt;
    wb_write(32'h200, 32'h0000_1234, 4'hF, 10, n);
    wb_read(32'h200, 3'b000, 60, n);
    chk("raw_write_first", done_cnt - d0, 1);
    chk("raw_stalled", n > 3, 1'b1);
    idle();
    tick();

    // 4-beat incrementing read burst
    slv_lat = 1;
    for (int b = 0; b < 4; b++)
      wb_read(32'h300 + 32'(4 * b), (b < 3) ? 3'b010 : 3'b111, 20, n);
    wbs_stb_i = 1'b0;
    #1;
    chk("burst_idle", wbm_cyc_o, 1'b0);
    idle();
    tick();

    // downstream error is sticky; retry resends same entry
    slv_lat = 0;
    err_next = 1;
    wb_write(32'h400, 32'h1111_2222, 4'hF, 10, n);
    idle();
    drain(50);
    chk("err_set", wr_err_o, 1'b1);
    rty_left = 2;
    d0 = done_cnt;
    wb_write(32'h404, 32'h3333_4444, 4'h5, 10, n);
    idle();
    drain(50);
    chk("err_sticky", wr_err_o, 1'b1);
    chk("rty_one_done", done_cnt - d0, 1);
    wb_read(32'h404, 3'b000, 20, n);
    idle();
    tick();

    // reset mid-drain with three entries queued
    slv_hold = 1;
    for (int i = 0; i < 3; i++)
      wb_write(32'h600 + 32'(4 * i), $urandom, 4'hF, 10, n);
    idle();
    tick();
    chk("rst_drain_active", wbm_cyc_o, 1'b1);
    #2;
    wb_rst = 1'b1;
    #1;
    chk("rst_async_cyc", {wbm_cyc_o, wbm_stb_o}, 2'b00);
    exp_q.delete();
    for (int i = 0; i < 3; i++) ref_mem.delete(32'h600 + 32'(4 * i));
    tick();
    wb_rst = 1'b0;
    slv_hold = 0;
    d0 = done_cnt;
    any = 0;
    repeat (10) begin
      tick();
      any |= wbm_cyc_o;
    end
    chk("rst_no_xfer", done_cnt - d0, 0);
    chk("rst_cyc_low", any, 1'b0);
    chk("rst_err_clr", wr_err_o, 1'b0);
    wb_read(32'h600, 3'b000, 20, n);
    chk("rst_fifo_empty", n, 2);
    idle();
    tick();

    // random mix of write bursts and reads
    rnd_lat = 1;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
          if ($urandom_range(0, 3) == 0) rty_left = 1;
          a = 32'h800 + 32'(4 * $urandom_range(0, 7));
          wb_write(a, $urandom, 4'($urandom_range(1, 15)), 60, n);
        end
      end else begin
        a = 32'h800 + 32'(4 * $urandom_range(0, 7));
        wb_read(a, 3'b000, 100, n);
      end
      idle();
      tick();
    end
    drain(200);
    rnd_lat = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_ddr2_wrbuf.md
WB_DDR2_WRBUF -- requirements
Module: wb_ddr2_wrbuf

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 2, FIFO depth = 2**DEPTH_LOG2 write entries.
REQ-002 SHALL have port wb_clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port wb_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports wbs_adr_i[31:0], wbs_dat_i[31:0], wbs_sel_i[3:0], wbs_cti_i[2:0], wbs_bte_i[1:0], wbs_cyc_i, wbs_stb_i, wbs_we_i  input  Wishbone slave side from CPU/bus master.
REQ-005 SHALL have ports wbs_dat_o[31:0], wbs_ack_o, wbs_err_o, wbs_rty_o  output  slave-side responses.
REQ-006 SHALL have ports wbm_adr_o[31:0], wbm_dat_o[31:0], wbm_sel_o[3:0], wbm_cti_o[2:0], wbm_bte_o[1:0], wbm_cyc_o, wbm_stb_o, wbm_we_o  output  master side to one DDR2 arbiter port (wbmN_*).
REQ-007 SHALL have ports wbm_dat_i[31:0], wbm_ack_i, wbm_err_i, wbm_rty_i  input  arbiter-port responses.
REQ-008 SHALL have port wr_err_o  output  1  sticky flag: a posted write received wbm_err_i.

Function
REQ-009 SHALL post writes: beat accepted when wbs_cyc_i&wbs_stb_i&wbs_we_i&!full&!wbs_ack_o; {adr,dat,sel} pushed; wbs_ack_o high exactly one cycle later, single-cycle pulse.
REQ-010 SHALL accept burst writes (cti=010) beat by beat under REQ-009; each entry drains as classic single (cti=111, bte=00).
REQ-011 SHALL use registered full; push into full FIFO forbidden even if a pop occurs same cycle; write stalls (no ack) while full.
REQ-012 SHALL implement FSM IDLE, DRAIN, READ; reset state IDLE.
REQ-013 IDLE->DRAIN when FIFO non-empty; IDLE->READ when FIFO empty and read pending (cyc&stb&!we).
REQ-014 DRAIN: wbm_cyc_o=wbm_stb_o=wbm_we_o=1, head entry on adr/dat/sel; pop on wbm_ack_i or wbm_err_i; cyc held across entries; DRAIN->IDLE (cyc low ≥1 cycle) when last entry popped.
REQ-015 wbm_err_i in DRAIN SHALL set wr_err_o (cleared only by reset) and pop entry; wbm_rty_i in DRAIN SHALL retry same entry.
REQ-016 Reads SHALL stall (no wbs ack) while FIFO non-empty or DRAIN active, guaranteeing read-after-write ordering.
REQ-017 READ: wbm_* driven combinationally from wbs_* (we=0); wbs_ack_o=wbm_ack_i, wbs_err_o=wbm_err_i, wbs_rty_o=wbm_rty_i, wbs_dat_o=wbm_dat_i; zero added latency.
REQ-018 READ->IDLE on wbm_ack_i with wbs_cti_i≠010, or wbs_cyc_i low; writes not accepted in READ.
REQ-019 Outside READ, wbs_err_o=wbs_rty_o=0, wbs_dat_o=0; outside READ/DRAIN all wbm_* outputs 0.
REQ-020 Simultaneous push and pop (not full) SHALL both occur; occupancy unchanged.
REQ-021 Pointers SHALL be DEPTH_LOG2+1 bits, wrapping modulo 2**(DEPTH_LOG2+1); full/empty from MSB compare.

Reset
REQ-022 On wb_rst: FIFO emptied (posted writes discarded), state IDLE, wr_err_o=0, wbs_ack_o=0, all wbm_* outputs 0.
REQ-023 Reset asserted mid-DRAIN or mid-READ SHALL deassert wbm_cyc_o asynchronously.

Structure
REQ-024 Shared package wb_ddr2_pkg SHALL hold FSM state enum and CTI constants (CLASSIC=000, INCR=010, EOB=111).
REQ-025 FIFO SHALL be sub-module wb_ddr2_wrbuf_fifo (68-bit {adr,dat,sel}, params DEPTH_LOG2).

Verification
REQ-026 Write adr 0x100 dat 0xDEADBEEF sel F, wbm_ack_i after 5 cycles -> wbs_ack_o 1 cycle after stb; wbm write 0x100/0xDEADBEEF cti 111 appears.
REQ-027 Five back-to-back writes, DEPTH_LOG2=2, wbm_ack_i held low -> 4 acks, 5th stalls until first wbm_ack_i, then acked.
REQ-028 Write 0x200=0x1234 then read 0x200 -> read not forwarded until write acked downstream; returns 0x1234.
REQ-029 4-beat INCR read, cti 010,010,010,111 -> 4 wbs acks mirroring wbm_ack_i, FSM IDLE after 4th.
REQ-030 wbm_err_i on posted write -> wr_err_o=1 persists; next write drains normally.
REQ-031 wb_rst pulse with 3 entries queued mid-DRAIN -> wbm_cyc_o=0 immediately, no further wbm transfers, FIFO empty.
